mvb_merge_rr: RTL and testbench
===============================

# mvb_merge_rr

Round-robin MVB merge: collects words from RX_PORTS independent MVB input streams and emits them on a single MVB output, one whole word per cycle, tagged with its source port. It is the counterpart of the MVB fork and sits downstream of parallel per-port processing that the fork fanned out, restoring a single stream. Selection is word-granular and fair: no port is starved while it holds SRC_RDY.

## Interface
- RX_PORTS, 2, number of input MVB streams (≥1)
- ITEMS, 4, items per MVB word
- ITEM_WIDTH, 8, bits per item
- PORT_W, max(1, log2(RX_PORTS)), width of the source tag (derived, not overridden)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- RX_DATA  in  RX_PORTS*ITEMS*ITEM_WIDTH  input data, port i at slice i
- RX_VLD  in  RX_PORTS*ITEMS  per-item valid, port i at slice i
- RX_SRC_RDY  in  RX_PORTS  word present on port i
- RX_DST_RDY  out  RX_PORTS  port i word accepted this cycle
- TX_DATA  out  ITEMS*ITEM_WIDTH  output data
- TX_VLD  out  ITEMS  output item valid
- TX_PORT  out  PORT_W  index of source port of current TX word
- TX_SRC_RDY  out  1  output word present
- TX_DST_RDY  in  1  downstream accepts

## Operation
- One output register (DATA, VLD, PORT, SRC_RDY) plus round-robin pointer PTR (PORT_W bits).
- Register is FREE when TX_SRC_RDY=0 or TX_DST_RDY=1.
- When FREE: grant G = first port i with RX_SRC_RDY(i)=1, searching PTR, PTR+1, … wrapping modulo RX_PORTS.
- RX_DST_RDY(i) = FREE and a grant exists and G=i and RESET=0; all other bits 0. At most one bit set.
- On grant: register loads RX_DATA/RX_VLD slice G, TX_PORT←G, TX_SRC_RDY←1 if any RX_VLD bit of G is 1; PTR←(G+1) mod RX_PORTS (wrap when G=RX_PORTS-1).
- Word with SRC_RDY=1 and all VLD=0: accepted, dropped (TX_SRC_RDY←0 if nothing else loaded), PTR still advances.
- FREE and no request: TX_SRC_RDY←0, PTR unchanged.
- Item order inside a word and VLD pattern pass unchanged; no compaction.
- RX_PORTS=1: PTR constant 0, block degenerates to a registered pipe.

## Timing
- Reset (RESET=1 at a rising edge): TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, TX_PORT=0, PTR=0; RX_DST_RDY=0 combinationally while RESET=1. Reset mid-transfer discards the held word.
- Transfer on either side occurs when SRC_RDY and DST_RDY are both 1 at a rising edge.
- Latency: word accepted at edge n appears on TX from edge n (visible cycle n+1), i.e. 1 cycle.
- Throughput: 1 word/cycle with TX_DST_RDY constantly 1.
- While TX_SRC_RDY=1 and TX_DST_RDY=0: TX_* held stable, all RX_DST_RDY=0.
- RX_DST_RDY is combinational from TX_DST_RDY, TX_SRC_RDY, RX_SRC_RDY, PTR (no register on ready path).
- Fairness: with all ports continuously requesting, each port granted exactly once per RX_PORTS accepted words.

## Structure
- Sub-module mvb_rr_arbiter: RX_PORTS request vector + PTR in → one-hot grant, grant index, valid out; purely combinational, PTR register stays in mvb_merge_rr.
- PORT_W computed via math_pkg log2.
- Verification package holds RX_PORTS, ITEMS, ITEM_WIDTH, TRANSACTION_COUNT, CLK_PERIOD, RESET_TIME; scoreboard keeps one expected queue per source port, checked by TX_PORT.

## Test plan
- RX_PORTS=2, both ports SRC_RDY every cycle, TX_DST_RDY=1 → TX_PORT sequence 0,1,0,1…, one word/cycle, RX_DST_RDY alternates 01,10.
- Only port 1 active, words A,B,C → TX words A,B,C with TX_PORT=1 on 3 consecutive cycles; PTR wraps 0 each time.
- TX_DST_RDY=0 for 5 cycles with word held → TX_DATA/VLD/PORT stable, RX_DST_RDY=00 throughout; release → held word transfers, next grant follows.
- Port 0 sends word VLD=0000, port 1 sends VLD=0101 → first accepted, not emitted; TX gets port-1 word only, TX_VLD=0101.
- RESET asserted for 1 cycle while TX_SRC_RDY=1 → next cycle TX_SRC_RDY=0, TX_VLD=0, next grant starts at port 0.
- Random SRC_RDY/DST_RDY, 2000 words per port → per-port order preserved, no loss/duplication, no port waits more than RX_PORTS grants.

Source files
------------

// File: rtl/mvb_merge_rr_pkg.sv
// Shared definitions for the round-robin MVB merge.
//   port_w_f : width of a port index for a given number of ports, never below 1
//              bit so that a single-port merge still has a (constant) tag.
package mvb_merge_rr_pkg;

  function automatic int port_w_f(input int ports);
    int w;
    w = $clog2(ports);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/mvb_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requesting port found when searching ptr, ptr+1, ...
// with wrap-around modulo PORTS. The pointer register lives in the caller.
//   req     : per-port request vector
//   ptr     : port with highest priority this cycle
//   gnt_oh  : one-hot grant (all zero when nothing requests)
//   gnt_idx : index of the granted port (0 when nothing requests)
//   gnt_vld : a grant exists
module mvb_rr_arbiter
  import mvb_merge_rr_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int PW    = port_w_f(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PORTS-1:0] gnt_oh,
  output logic [PW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  // The wrapped search is split into two linear scans: first the ports at or
  // above the pointer, then the ports below it. This keeps every index a
  // loop constant.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (!gnt_vld && req[i] && (PW'(i) >= ptr)) begin
        gnt_vld   = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      if (!gnt_vld && req[i] && (PW'(i) < ptr)) begin
        gnt_vld   = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
  end

endmodule

// File: rtl/mvb_merge_rr.sv
// Round-robin MVB merge: collects whole words from RX_PORTS MVB streams and
// emits them one per cycle on a single registered MVB output, tagged with the
// source port. Words whose valid bits are all zero are accepted and dropped.
//   CLK, RESET  : clock, synchronous active-high reset
//   RX_DATA     : RX_PORTS words of ITEMS*ITEM_WIDTH bits, port i at slice i
//   RX_VLD      : RX_PORTS groups of ITEMS item-valid bits
//   RX_SRC_RDY  : word present on port i
//   RX_DST_RDY  : word on port i accepted this cycle (at most one bit set)
//   TX_DATA/TX_VLD/TX_PORT : output word, item valids, source port index
//   TX_SRC_RDY  : output word present
//   TX_DST_RDY  : downstream accepts
module mvb_merge_rr
  import mvb_merge_rr_pkg::*;
#(
  parameter int  RX_PORTS   = 2,
  parameter int  ITEMS      = 4,
  parameter int  ITEM_WIDTH = 8,
  localparam int PORT_W     = port_w_f(RX_PORTS)
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [RX_PORTS*ITEMS*ITEM_WIDTH-1:0] RX_DATA,
  input  logic [RX_PORTS*ITEMS-1:0]        RX_VLD,
  input  logic [RX_PORTS-1:0]              RX_SRC_RDY,
  output logic [RX_PORTS-1:0]              RX_DST_RDY,
  output logic [ITEMS*ITEM_WIDTH-1:0]      TX_DATA,
  output logic [ITEMS-1:0]                 TX_VLD,
  output logic [PORT_W-1:0]                TX_PORT,
  output logic                             TX_SRC_RDY,
  input  logic                             TX_DST_RDY
);

  localparam int WORD_W = ITEMS * ITEM_WIDTH;

  logic [WORD_W-1:0]   tx_data_q, tx_data_d;
  logic [ITEMS-1:0]    tx_vld_q, tx_vld_d;
  logic [PORT_W-1:0]   tx_port_q, tx_port_d;
  logic                tx_src_rdy_q, tx_src_rdy_d;
  logic [PORT_W-1:0]   ptr_q, ptr_d;

  logic [RX_PORTS-1:0] gnt_oh;
  logic [PORT_W-1:0]   gnt_idx;
  logic                gnt_vld;
  logic                free;
  logic                take;

  mvb_rr_arbiter #(
    .PORTS (RX_PORTS),
    .PW    (PORT_W)
  ) u_arb (
    .req     (RX_SRC_RDY),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // The output register can take a new word when it is empty or its current
  // word leaves this cycle; the ready path stays purely combinational.
  assign free       = !tx_src_rdy_q || TX_DST_RDY;
  assign take       = free && gnt_vld && !RESET;
  assign RX_DST_RDY = take ? gnt_oh : '0;

  always_comb begin
    tx_data_d    = tx_data_q;
    tx_vld_d     = tx_vld_q;
    tx_port_d    = tx_port_q;
    tx_src_rdy_d = tx_src_rdy_q;
    ptr_d        = ptr_q;
    if (free) begin
      if (gnt_vld) begin
        for (int i = 0; i < RX_PORTS; i++) begin
          if (gnt_oh[i]) begin
            tx_data_d = RX_DATA[i*WORD_W +: WORD_W];
            tx_vld_d  = RX_VLD[i*ITEMS +: ITEMS];
          end
        end
        tx_port_d    = gnt_idx;
        // A word without any valid item is consumed but never presented.
        tx_src_rdy_d = |tx_vld_d;
        ptr_d        = (gnt_idx == PORT_W'(RX_PORTS - 1)) ? '0 : gnt_idx + PORT_W'(1);
      end else begin
        tx_src_rdy_d = 1'b0;
      end
    end
  end

  // Output register stage
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_data_q    <= '0;
      tx_vld_q     <= '0;
      tx_port_q    <= '0;
      tx_src_rdy_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
      tx_port_q    <= tx_port_d;
      tx_src_rdy_q <= tx_src_rdy_d;
      ptr_q        <= ptr_d;
    end
  end

  assign TX_DATA    = tx_data_q;
  assign TX_VLD     = tx_vld_q;
  assign TX_PORT    = tx_port_q;
  assign TX_SRC_RDY = tx_src_rdy_q;

endmodule

// File: tb/tb_mvb_merge_rr.sv
module tb_mvb_merge_rr;

  localparam int RX_PORTS          = 2;
  localparam int ITEMS             = 4;
  localparam int ITEM_WIDTH        = 8;
  localparam int PORT_W            = 1;
  localparam int WORD_W            = ITEMS * ITEM_WIDTH;
  localparam int TRANSACTION_COUNT = 2000;
  localparam int CLK_PERIOD        = 10;
  localparam int MAX_CYCLES        = 60000;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [RX_PORTS*WORD_W-1:0]   rx_data;
  logic [RX_PORTS*ITEMS-1:0]    rx_vld;
  logic [RX_PORTS-1:0]          rx_src_rdy;
  logic [RX_PORTS-1:0]          rx_dst_rdy;
  logic [WORD_W-1:0]            tx_data;
  logic [ITEMS-1:0]             tx_vld;
  logic [PORT_W-1:0]            tx_port;
  logic                         tx_src_rdy;
  logic                         tx_dst_rdy;

  logic [WORD_W-1:0]            p_data [RX_PORTS];
  logic [ITEMS-1:0]             p_vld  [RX_PORTS];

  logic [ITEMS+WORD_W-1:0]      exp_q  [RX_PORTS][$];

  int passed = 0;
  int total  = 0;

  always #(CLK_PERIOD/2) clk = ~clk;

  always_comb begin
    rx_data = '0;
    rx_vld  = '0;
    for (int i = 0; i < RX_PORTS; i++) begin
      rx_data[i*WORD_W +: WORD_W] = p_data[i];
      rx_vld[i*ITEMS +: ITEMS]    = p_vld[i];
    end
  end

  mvb_merge_rr #(
    .RX_PORTS   (RX_PORTS),
    .ITEMS      (ITEMS),
    .ITEM_WIDTH (ITEM_WIDTH)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .RX_DATA    (rx_data),
    .RX_VLD     (rx_vld),
    .RX_SRC_RDY (rx_src_rdy),
    .RX_DST_RDY (rx_dst_rdy),
    .TX_DATA    (tx_data),
    .TX_VLD     (tx_vld),
    .TX_PORT    (tx_port),
    .TX_SRC_RDY (tx_src_rdy),
    .TX_DST_RDY (tx_dst_rdy)
  );

  task automatic do_reset();
    rst        = 1'b1;
    rx_src_rdy = '0;
    tx_dst_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    rx_src_rdy = '1;
    tx_dst_rdy = 1'b1;
    for (int p = 0; p < RX_PORTS; p++) begin
      p_data[p] = $urandom;
      p_vld[p]  = 4'hF;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (rx_dst_rdy !== 2'b00) $display("FAIL reset_rx_dst_rdy got %b want 00", rx_dst_rdy);
    else passed++;
    total++;
    if ({tx_src_rdy, tx_port, tx_vld} !== {1'b0, 1'b0, 4'h0})
      $display("FAIL reset_tx_ctrl got src=%b port=%0d vld=%b want 0/0/0000", tx_src_rdy, tx_port, tx_vld);
    else passed++;
    total++;
    if (tx_data !== '0) $display("FAIL reset_tx_data got %h want 0", tx_data);
    else passed++;
    rx_src_rdy = '0;
    rst        = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [WORD_W-1:0]   prev [RX_PORTS];
    logic [RX_PORTS-1:0] want;
    logic [PORT_W-1:0]   wport;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int p = 0; p < RX_PORTS; p++) begin
        p_data[p] = $urandom;
        p_vld[p]  = 4'hF;
      end
      rx_src_rdy = '1;
      tx_dst_rdy = 1'b1;
      #1;
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (rx_dst_rdy !== want) $display("FAIL rr_rdy k=%0d got %b want %b", k, rx_dst_rdy, want);
      else passed++;
      if (k > 0) begin
        wport = PORT_W'((k - 1) % 2);
        total++;
        if ({tx_src_rdy, tx_port, tx_data} !== {1'b1, wport, prev[(k-1)%2]})
          $display("FAIL rr_tx k=%0d got src=%b port=%0d data=%h want 1/%0d/%h",
                   k, tx_src_rdy, tx_port, tx_data, wport, prev[(k-1)%2]);
        else passed++;
      end
      for (int p = 0; p < RX_PORTS; p++) prev[p] = p_data[p];
    end
    rx_src_rdy = '0;
  endtask

  task automatic test_single_port();
    logic [WORD_W-1:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tx_dst_rdy = 1'b1;
      p_vld[1]   = 4'hF;
      if (k < 3) begin
        p_data[1]  = w[k];
        rx_src_rdy = 2'b10;
      end else begin
        rx_src_rdy = 2'b00;
      end
      #1;
      if (k < 3) begin
        total++;
        if (rx_dst_rdy !== 2'b10) $display("FAIL single_rdy k=%0d got %b want 10", k, rx_dst_rdy);
        else passed++;
      end
      if (k >= 1 && k <= 3) begin
        total++;
        if ({tx_src_rdy, tx_port, tx_vld, tx_data} !== {1'b1, 1'b1, 4'hF, w[k-1]})
          $display("FAIL single_tx k=%0d got src=%b port=%0d data=%h want 1/1/%h",
                   k, tx_src_rdy, tx_port, tx_data, w[k-1]);
        else passed++;
      end
      if (k == 4) begin
        total++;
        if (tx_src_rdy !== 1'b0) $display("FAIL single_idle got src=%b want 0", tx_src_rdy);
        else passed++;
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [WORD_W-1:0] w0, w0b, w1b;
    w0 = $urandom; w0b = $urandom; w1b = $urandom;
    do_reset();
    @(negedge clk);
    p_data[0] = w0; p_vld[0] = 4'hF; rx_src_rdy = 2'b01; tx_dst_rdy = 1'b1;
    #1;
    total++;
    if (rx_dst_rdy !== 2'b01) $display("FAIL bp_first_rdy got %b want 01", rx_dst_rdy);
    else passed++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      p_data[0] = w0b; p_data[1] = w1b; p_vld[1] = 4'hF;
      rx_src_rdy = 2'b11;
      tx_dst_rdy = (k == 6);
      #1;
      total++;
      if ({tx_src_rdy, tx_port, tx_vld, tx_data} !== {1'b1, 1'b0, 4'hF, w0})
        $display("FAIL bp_hold k=%0d got src=%b port=%0d vld=%b data=%h want 1/0/1111/%h",
                 k, tx_src_rdy, tx_port, tx_vld, tx_data, w0);
      else passed++;
      total++;
      if (rx_dst_rdy !== ((k == 6) ? 2'b10 : 2'b00))
        $display("FAIL bp_rdy k=%0d got %b want %b", k, rx_dst_rdy, (k == 6) ? 2'b10 : 2'b00);
      else passed++;
    end
    @(negedge clk);
    rx_src_rdy = 2'b01;
    tx_dst_rdy = 1'b1;
    #1;
    total++;
    if ({tx_src_rdy, tx_port, tx_data, rx_dst_rdy} !== {1'b1, 1'b1, w1b, 2'b01})
      $display("FAIL bp_release got src=%b port=%0d data=%h rdy=%b want 1/1/%h/01",
               tx_src_rdy, tx_port, tx_data, rx_dst_rdy, w1b);
    else passed++;
    @(negedge clk);
    rx_src_rdy = 2'b00;
    #1;
    total++;
    if ({tx_src_rdy, tx_port, tx_data} !== {1'b1, 1'b0, w0b})
      $display("FAIL bp_next got src=%b port=%0d data=%h want 1/0/%h", tx_src_rdy, tx_port, tx_data, w0b);
    else passed++;
  endtask

  task automatic test_empty_word();
    logic [WORD_W-1:0] w1;
    w1 = $urandom;
    do_reset();
    @(negedge clk);
    p_data[0] = $urandom; p_vld[0] = 4'b0000;
    p_data[1] = w1;       p_vld[1] = 4'b0101;
    rx_src_rdy = 2'b11; tx_dst_rdy = 1'b1;
    #1;
    total++;
    if (rx_dst_rdy !== 2'b01) $display("FAIL empty_rdy0 got %b want 01", rx_dst_rdy);
    else passed++;
    @(negedge clk);
    rx_src_rdy = 2'b10;
    #1;
    total++;
    if ({tx_src_rdy, rx_dst_rdy} !== {1'b0, 2'b10})
      $display("FAIL empty_drop got src=%b rdy=%b want 0/10", tx_src_rdy, rx_dst_rdy);
    else passed++;
    @(negedge clk);
    rx_src_rdy = 2'b00;
    #1;
    total++;
    if ({tx_src_rdy, tx_port, tx_vld, tx_data} !== {1'b1, 1'b1, 4'b0101, w1})
      $display("FAIL empty_tx got src=%b port=%0d vld=%b data=%h want 1/1/0101/%h",
               tx_src_rdy, tx_port, tx_vld, tx_data, w1);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (tx_src_rdy !== 1'b0) $display("FAIL empty_idle got src=%b want 0", tx_src_rdy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [WORD_W-1:0] a, b;
    a = $urandom; b = $urandom;
    do_reset();
    @(negedge clk);
    p_data[0] = a; p_vld[0] = 4'hF; rx_src_rdy = 2'b01; tx_dst_rdy = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b1; tx_dst_rdy = 1'b0;
    p_data[0] = b; p_data[1] = $urandom; p_vld[1] = 4'hF; rx_src_rdy = 2'b11;
    #1;
    total++;
    if ({rx_dst_rdy, tx_src_rdy, tx_port, tx_data} !== {2'b00, 1'b1, 1'b0, a})
      $display("FAIL rmid_before got rdy=%b src=%b port=%0d data=%h want 00/1/0/%h",
               rx_dst_rdy, tx_src_rdy, tx_port, tx_data, a);
    else passed++;
    @(negedge clk);
    rst = 1'b0; tx_dst_rdy = 1'b1;
    #1;
    total++;
    if ({tx_src_rdy, tx_vld, rx_dst_rdy} !== {1'b0, 4'h0, 2'b01})
      $display("FAIL rmid_after got src=%b vld=%b rdy=%b want 0/0000/01", tx_src_rdy, tx_vld, rx_dst_rdy);
    else passed++;
    @(negedge clk);
    rx_src_rdy = 2'b00;
    #1;
    total++;
    if ({tx_src_rdy, tx_port, tx_data} !== {1'b1, 1'b0, b})
      $display("FAIL rmid_next got src=%b port=%0d data=%h want 1/0/%h", tx_src_rdy, tx_port, tx_data, b);
    else passed++;
  endtask

  task automatic test_random();
    int                sent  [RX_PORTS];
    int                waitc [RX_PORTS];
    bit                has   [RX_PORTS];
    logic [WORD_W-1:0] wd    [RX_PORTS];
    logic [ITEMS-1:0]  wv    [RX_PORTS];
    int                mptr, g, cycles, nonzero, got;
    bit                m_txv, free, done;
    logic [RX_PORTS-1:0]     want;
    logic [ITEMS+WORD_W-1:0] e;
    for (int p = 0; p < RX_PORTS; p++) begin
      sent[p] = 0; waitc[p] = 0; has[p] = 0; wd[p] = '0; wv[p] = '0;
      exp_q[p].delete();
    end
    mptr = 0; m_txv = 0; cycles = 0; nonzero = 0; got = 0; done = 0;
    do_reset();
    while (!done && cycles < MAX_CYCLES) begin
      @(negedge clk);
      cycles++;
      for (int p = 0; p < RX_PORTS; p++) begin
        if (!has[p] && sent[p] < TRANSACTION_COUNT && $urandom_range(0, 3) != 0) begin
          has[p] = 1;
          wd[p]  = $urandom;
          wv[p]  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
          sent[p]++;
        end
        rx_src_rdy[p] = has[p] && ($urandom_range(0, 4) != 0);
        p_data[p]     = wd[p];
        p_vld[p]      = wv[p];
      end
      tx_dst_rdy = ($urandom_range(0, 9) < 7);
      #1;
      total++;
      if (tx_src_rdy !== m_txv) $display("FAIL rnd_src_rdy cyc=%0d got %b want %b", cycles, tx_src_rdy, m_txv);
      else passed++;
      if (m_txv && tx_dst_rdy) begin
        total++;
        if (exp_q[tx_port].size() == 0) begin
          $display("FAIL rnd_unexpected cyc=%0d port=%0d data=%h", cycles, tx_port, tx_data);
        end else begin
          e = exp_q[tx_port].pop_front();
          got++;
          if ({tx_vld, tx_data} !== e)
            $display("FAIL rnd_word cyc=%0d port=%0d got %h want %h", cycles, tx_port, {tx_vld, tx_data}, e);
          else passed++;
        end
      end
      free = !m_txv || tx_dst_rdy;
      g = -1;
      if (free) begin
        for (int k = 0; k < RX_PORTS; k++) begin
          if (g < 0 && rx_src_rdy[(mptr + k) % RX_PORTS]) g = (mptr + k) % RX_PORTS;
        end
      end
      want = (g >= 0) ? RX_PORTS'(1 << g) : '0;
      total++;
      if (rx_dst_rdy !== want) $display("FAIL rnd_rdy cyc=%0d got %b want %b", cycles, rx_dst_rdy, want);
      else passed++;
      if (free) m_txv = (g >= 0) && (|wv[g]);
      if (g >= 0) begin
        if (|wv[g]) begin
          exp_q[g].push_back({wv[g], wd[g]});
          nonzero++;
        end
        has[g] = 0;
        mptr   = (g + 1) % RX_PORTS;
        for (int p = 0; p < RX_PORTS; p++) begin
          if (p == g || !rx_src_rdy[p]) waitc[p] = 0;
          else waitc[p]++;
          if (p != g && rx_src_rdy[p]) begin
            total++;
            if (waitc[p] >= RX_PORTS) $display("FAIL rnd_starve cyc=%0d port=%0d waited %0d grants", cycles, p, waitc[p]);
            else passed++;
          end
        end
      end
      done = !m_txv;
      for (int p = 0; p < RX_PORTS; p++)
        if (sent[p] < TRANSACTION_COUNT || has[p] || exp_q[p].size() != 0) done = 0;
    end
    rx_src_rdy = '0;
    total++;
    if (!done) $display("FAIL rnd_timeout after %0d cycles, words out %0d want %0d", cycles, got, nonzero);
    else passed++;
    total++;
    if (got != nonzero) $display("FAIL rnd_count got %0d want %0d", got, nonzero);
    else passed++;
  endtask

  initial begin
    rst        = 1'b1;
    rx_src_rdy = '0;
    tx_dst_rdy = 1'b0;
    for (int p = 0; p < RX_PORTS; p++) begin
      p_data[p] = '0;
      p_vld[p]  = '0;
    end
    test_reset();
    test_round_robin();
    test_single_port();
    test_back_pressure();
    test_empty_word();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
